swan128_key_expand_256: RTL
===========================

Name: swan128_key_expand_256

Overview:
- Sequential round-key generator for the SWAN128 encryption datapath with a 256-bit key.
- Accepts a 256-bit master key over a valid/ready handshake.
- Iterates the combinational key-schedule step (enc_key_schedule_256) once per accepted output.
- Streams the 64-bit round keys, in round order, to the round core over a second valid/ready handshake. Sits between the key-load interface and the encryption round pipeline.

Parameters:
KEY_SIZE, 256, master key width in bits.
SIDE_SIZE, 64, round-key and delta width in bits.
ROUNDS, 64, number of round keys produced per loaded key.
DELTA_INIT, 64'h0, delta register value at key load.
RW, 6, round-index width (ceil log2 ROUNDS).

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous active-low reset.
key_valid  input  1  master key offered.
key_ready  output  1  block can accept a key (high only in IDLE).
key_in  input  KEY_SIZE  master key, bit 0 = MSB.
sk_valid  output  1  sk_out holds a valid round key.
sk_ready  input  1  round core accepts sk_out this cycle.
sk_out  output  SIDE_SIZE  current round key.
sk_round  output  RW  index of the round key on sk_out (0..ROUNDS-1).
sk_last  output  1  high with sk_valid when sk_round == ROUNDS-1.
flush  input  1  synchronous abort, returns to IDLE.
busy  output  1  high in RUN.

Behaviour:
- Single clock domain. Reset is asynchronous and active-low.
- While rst_n is low, all state clears: state IDLE, key_ready 1, sk_valid 0, sk_out 0, sk_round 0, sk_last 0, busy 0, key/delta registers 0. Reset mid-stream abandons the stream with no further outputs.
- Step function F(K, D), with K a 256-bit key and D a 64-bit delta:
  - R = K rotated right by 56 bits, i.e. {K[200:255], K[0:199]}.
  - D' = D + 64'h9e3779b97f4a7c15, mod 2^64.
  - S = R[192:255] + D', mod 2^64.
  - K' = {R[0:191], S}.
  - Implemented by instantiating enc_key_schedule_256; no reimplementation.
- States: IDLE and RUN.
- IDLE:
  - key_ready = 1.
  - On key_valid, apply F(key_in, DELTA_INIT) and load the results in the same edge: sk_out <= S, key_q <= K', delta_q <= D', sk_round <= 0, sk_valid <= 1. Go to RUN.
  - Latency: key accepted at edge N, first round key valid after edge N.
- RUN:
  - key_ready = 0; key_valid is ignored.
  - sk_out, sk_round and sk_last hold stable while sk_valid && !sk_ready.
  - On handshake (sk_valid && sk_ready):
    - If sk_round == ROUNDS-1: sk_valid <= 0, go to IDLE. key_ready rises the next cycle, so there is no same-cycle reload.
    - Else: apply F(key_q, delta_q), load sk_out/key_q/delta_q, sk_round++. Throughput is one round key per cycle.
- flush:
  - Highest priority after reset, in any state.
  - Next state IDLE, sk_valid 0, sk_round 0. Key/delta registers are don't-care.
  - flush together with key_valid in IDLE: flush wins, key not accepted.
- sk_last = sk_valid && (sk_round == ROUNDS-1), registered alongside sk_round.
- sk_round wraps only by returning to IDLE; it never counts past ROUNDS-1.

Decomposition:
- Shared package swan_pkg holds:
  - constants SWAN_DELTA0 = 64'h9e3779b97f4a7c15, SWAN_PD = 56, SWAN_SIDE = 64, SWAN_KEY256 = 256;
  - state enum {IDLE, RUN}.
- One sub-module: enc_key_schedule_256, with a single instance whose inputs are muxed between (key_in, DELTA_INIT) in IDLE and (key_q, delta_q) in RUN.

Test Plan:
- Zero key, sk_ready held 1:
  - round 0 sk_out = 64'h9e3779b97f4a7c15;
  - round 1 sk_out = 64'h3c6ef372fe94f8c8;
  - 64 consecutive valid cycles; sk_last only on round 63; key_ready returns 1 one cycle after.
- Key all-ones -> round 0 sk_out = 64'h9e3779b97f4a7c14, sk_round 0. Full 64-key sequence matches a software model of F.
- Backpressure: toggle sk_ready randomly -> sk_out/sk_round stable while stalled, no skipped or duplicated round, same sequence as the unstalled run.
- key_valid asserted during RUN -> ignored, key_ready 0, stream unaffected; new key accepted only after return to IDLE.
- flush at round 10 -> sk_valid 0 next cycle, IDLE. A subsequent zero key restarts at round 0 with 64'h9e3779b97f4a7c15 (delta re-initialised).
- rst_n pulsed low asynchronously mid-round-20 -> outputs cleared immediately without a clock edge; after release key_ready = 1, sk_valid = 0.

Source files
------------

// File: rtl/swan_pkg.sv
// Shared SWAN128 key-schedule constants and the key-expander state encoding.
package swan_pkg;

  // Golden-ratio increment added to the delta register on every schedule step.
  localparam logic [63:0] SWAN_DELTA0 = 64'h9e3779b97f4a7c15;

  // Right-rotation distance applied to the 256-bit key on every step.
  localparam int SWAN_PD = 56;

  // Round-key / delta width.
  localparam int SWAN_SIDE = 64;

  // Master key width for the 256-bit variant.
  localparam int SWAN_KEY256 = 256;

  // Key-expander control states.
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } swan_state_e;

endpackage : swan_pkg

// File: rtl/enc_key_schedule_256.sv
// One combinational SWAN128 key-schedule step for a 256-bit key.
//   R  = key rotated right by SWAN_PD bits
//   D' = delta + SWAN_DELTA0
//   S  = low word of R + D'   (this is the emitted round key)
//   K' = R with its low word replaced by S
// Vector bit 255 is the key's MSB (bit 0 in the MSB-first notation).
module enc_key_schedule_256
  import swan_pkg::*;
(
  input  logic [SWAN_KEY256-1:0] key_in,
  input  logic [SWAN_SIDE-1:0]   delta_in,
  output logic [SWAN_KEY256-1:0] key_out,
  output logic [SWAN_SIDE-1:0]   delta_out,
  output logic [SWAN_SIDE-1:0]   sk
);

  logic [SWAN_KEY256-1:0] rot_s;
  logic [SWAN_SIDE-1:0]   delta_next_s;
  logic [SWAN_SIDE-1:0]   sk_s;

  // Rotate, advance delta, and fold the new delta into the low key word.
  always_comb begin
    rot_s        = {key_in[SWAN_PD-1:0], key_in[SWAN_KEY256-1:SWAN_PD]};
    delta_next_s = delta_in + SWAN_DELTA0;
    sk_s         = rot_s[SWAN_SIDE-1:0] + delta_next_s;
    key_out      = {rot_s[SWAN_KEY256-1:SWAN_SIDE], sk_s};
    delta_out    = delta_next_s;
    sk           = sk_s;
  end

endmodule : enc_key_schedule_256

// File: rtl/swan128_key_expand_256.sv
// SWAN128 256-bit round-key expander.
// Accepts a master key in IDLE, then streams ROUNDS round keys in order over
// a valid/ready handshake, advancing the key schedule once per accepted key.
// flush aborts the stream from any state; rst_n clears everything at once.
module swan128_key_expand_256
  import swan_pkg::*;
#(
  parameter int                    KEY_SIZE   = 256,
  parameter int                    SIDE_SIZE  = 64,
  parameter int                    ROUNDS     = 64,
  parameter logic [SIDE_SIZE-1:0]  DELTA_INIT = 64'h0,
  parameter int                    RW         = 6
)(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 key_valid,
  output logic                 key_ready,
  input  logic [KEY_SIZE-1:0]  key_in,
  output logic                 sk_valid,
  input  logic                 sk_ready,
  output logic [SIDE_SIZE-1:0] sk_out,
  output logic [RW-1:0]        sk_round,
  output logic                 sk_last,
  input  logic                 flush,
  output logic                 busy
);

  localparam logic [RW-1:0] LAST_ROUND = RW'(ROUNDS - 1);
  localparam logic [RW-1:0] ROUND_ONE  = RW'(1);
  localparam logic [RW-1:0] ROUND_ZERO = {RW{1'b0}};

  // Registered state and datapath.
  swan_state_e           state_r;
  logic [KEY_SIZE-1:0]   key_r;
  logic [SIDE_SIZE-1:0]  delta_r;
  logic [SIDE_SIZE-1:0]  sk_out_r;
  logic [RW-1:0]         sk_round_r;
  logic                  sk_valid_r;
  logic                  sk_last_r;

  // Next-state values.
  swan_state_e           state_n;
  logic [KEY_SIZE-1:0]   key_n;
  logic [SIDE_SIZE-1:0]  delta_n;
  logic [SIDE_SIZE-1:0]  sk_out_n;
  logic [RW-1:0]         sk_round_n;
  logic                  sk_valid_n;
  logic                  sk_last_n;

  // Schedule-step operands and results.
  logic [KEY_SIZE-1:0]   sched_key_s;
  logic [SIDE_SIZE-1:0]  sched_delta_s;
  logic [KEY_SIZE-1:0]   sched_key_next_s;
  logic [SIDE_SIZE-1:0]  sched_delta_next_s;
  logic [SIDE_SIZE-1:0]  sched_sk_s;
  logic [RW-1:0]         round_inc_s;
  logic                  handshake_s;

  // Single schedule instance shared between key load and streaming.
  enc_key_schedule_256 u_sched (
    .key_in    (sched_key_s),
    .delta_in  (sched_delta_s),
    .key_out   (sched_key_next_s),
    .delta_out (sched_delta_next_s),
    .sk        (sched_sk_s)
  );

  // Feed the schedule from the incoming master key in IDLE, from the stored
  // key/delta while streaming.
  always_comb begin
    if (state_r == RUN) begin
      sched_key_s   = key_r;
      sched_delta_s = delta_r;
    end else begin
      sched_key_s   = key_in;
      sched_delta_s = DELTA_INIT;
    end
  end

  // Next-state and next-output logic; flush overrides every state.
  always_comb begin
    state_n     = state_r;
    key_n       = key_r;
    delta_n     = delta_r;
    sk_out_n    = sk_out_r;
    sk_round_n  = sk_round_r;
    sk_valid_n  = sk_valid_r;
    sk_last_n   = sk_last_r;
    round_inc_s = sk_round_r + ROUND_ONE;
    handshake_s = sk_valid_r & sk_ready;

    if (flush) begin
      state_n    = IDLE;
      sk_valid_n = 1'b0;
      sk_round_n = ROUND_ZERO;
      sk_last_n  = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (key_valid) begin
            key_n      = sched_key_next_s;
            delta_n    = sched_delta_next_s;
            sk_out_n   = sched_sk_s;
            sk_round_n = ROUND_ZERO;
            sk_valid_n = 1'b1;
            sk_last_n  = (LAST_ROUND == ROUND_ZERO);
            state_n    = RUN;
          end else begin
            sk_valid_n = 1'b0;
            sk_last_n  = 1'b0;
          end
        end
        RUN: begin
          if (handshake_s) begin
            if (sk_round_r == LAST_ROUND) begin
              // Last key consumed: key_ready only rises on the next cycle.
              sk_valid_n = 1'b0;
              sk_last_n  = 1'b0;
              sk_round_n = ROUND_ZERO;
              state_n    = IDLE;
            end else begin
              key_n      = sched_key_next_s;
              delta_n    = sched_delta_next_s;
              sk_out_n   = sched_sk_s;
              sk_round_n = round_inc_s;
              sk_last_n  = (round_inc_s == LAST_ROUND);
            end
          end else begin
            // Stalled: hold the presented round key.
            sk_valid_n = sk_valid_r;
          end
        end
        default: begin
          state_n    = IDLE;
          sk_valid_n = 1'b0;
          sk_round_n = ROUND_ZERO;
          sk_last_n  = 1'b0;
        end
      endcase
    end
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      key_r      <= {KEY_SIZE{1'b0}};
      delta_r    <= {SIDE_SIZE{1'b0}};
      sk_out_r   <= {SIDE_SIZE{1'b0}};
      sk_round_r <= ROUND_ZERO;
      sk_valid_r <= 1'b0;
      sk_last_r  <= 1'b0;
    end else begin
      state_r    <= state_n;
      key_r      <= key_n;
      delta_r    <= delta_n;
      sk_out_r   <= sk_out_n;
      sk_round_r <= sk_round_n;
      sk_valid_r <= sk_valid_n;
      sk_last_r  <= sk_last_n;
    end
  end

  assign key_ready = (state_r == IDLE);
  assign busy      = (state_r == RUN);
  assign sk_valid  = sk_valid_r;
  assign sk_out    = sk_out_r;
  assign sk_round  = sk_round_r;
  assign sk_last   = sk_last_r;

endmodule : swan128_key_expand_256
